// File: rtl/regfile_pkg.sv
// Shared register-file parameters and requester select type.
// Used by the write-back arbiter, scoreboard, register file and decoder.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one Busy bit per register.
// Drives Issue_Ready (WAW) and Stall (RAW) for the decoder.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Addr,
    output logic              Issue_Ready,
    input  logic [ADDR_W-1:0] Rd_Addr_A,
    input  logic [ADDR_W-1:0] Rd_Addr_B,
    output logic              Stall,
    input  logic              WE,
    input  logic [ADDR_W-1:0] W_Addr,
    output logic [NREG-1:0]   Busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            set_en;

    always_comb begin
        Issue_Ready = (Issue_Addr == '0) | ~busy_q[Issue_Addr];
        Stall = ((Rd_Addr_A != '0) & busy_q[Rd_Addr_A])
              | ((Rd_Addr_B != '0) & busy_q[Rd_Addr_B]);
        set_en = Issue_Valid & Issue_Ready & (Issue_Addr != '0);
    end

    // Clear applied first so a same-edge set on the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (WE)
            busy_d[W_Addr] = 1'b0;
        if (set_en)
            busy_d[Issue_Addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign Busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// with a pending-write scoreboard for RAW/WAW hazard detection.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_Valid,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Ready,
    input  logic              B_Valid,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_Data,
    output logic              B_Ready,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Addr,
    output logic              Issue_Ready,
    input  logic [ADDR_W-1:0] Rd_Addr_A,
    input  logic [ADDR_W-1:0] Rd_Addr_B,
    output logic              Stall,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              WE,
    output logic [NREG-1:0]   Busy
);

    req_sel_e rr_q;
    req_sel_e rr_d;
    logic     a_nz;
    logic     b_nz;
    logic     grant_a;
    logic     grant_b;
    logic     contended;

    always_comb begin
        a_nz      = A_Valid & (A_Addr != '0);
        b_nz      = B_Valid & (B_Addr != '0);
        contended = a_nz & b_nz;
        grant_a   = a_nz & (~b_nz | (rr_q == REQ_A));
        grant_b   = b_nz & (~a_nz | (rr_q == REQ_B));
        // Zero-address requests are swallowed without using the port.
        A_Ready   = A_Valid & ((A_Addr == '0) | grant_a);
        B_Ready   = B_Valid & ((B_Addr == '0) | grant_b);
    end

    always_comb begin
        rr_d = rr_q;
        if (contended)
            rr_d = grant_a ? REQ_B : REQ_A;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rr_q <= REQ_A;
        else
            rr_q <= rr_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE     <= 1'b0;
            W_Addr <= '0;
            W_Data <= '0;
        end else begin
            WE <= grant_a | grant_b;
            if (grant_a) begin
                W_Addr <= A_Addr;
                W_Data <= A_Data;
            end else if (grant_b) begin
                W_Addr <= B_Addr;
                W_Data <= B_Data;
            end
        end
    end

    regfile_scoreboard u_sb (
        .CLK         (CLK),
        .RST         (RST),
        .Issue_Valid (Issue_Valid),
        .Issue_Addr  (Issue_Addr),
        .Issue_Ready (Issue_Ready),
        .Rd_Addr_A   (Rd_Addr_A),
        .Rd_Addr_B   (Rd_Addr_B),
        .Stall       (Stall),
        .WE          (WE),
        .W_Addr      (W_Addr),
        .Busy        (Busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter.
// Inputs change at the falling edge; outputs are checked 2 ns later.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_Valid, B_Valid, Issue_Valid;
    logic [4:0]  A_Addr, B_Addr, Issue_Addr, Rd_Addr_A, Rd_Addr_B;
    logic [31:0] A_Data, B_Data;
    logic        A_Ready, B_Ready, Issue_Ready, Stall, WE;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [31:0] Busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .A_Valid     (A_Valid),
        .A_Addr      (A_Addr),
        .A_Data      (A_Data),
        .A_Ready     (A_Ready),
        .B_Valid     (B_Valid),
        .B_Addr      (B_Addr),
        .B_Data      (B_Data),
        .B_Ready     (B_Ready),
        .Issue_Valid (Issue_Valid),
        .Issue_Addr  (Issue_Addr),
        .Issue_Ready (Issue_Ready),
        .Rd_Addr_A   (Rd_Addr_A),
        .Rd_Addr_B   (Rd_Addr_B),
        .Stall       (Stall),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data),
        .WE          (WE),
        .Busy        (Busy)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ar;
        logic        br;
        logic        ir;
        logic        st;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic ar, input logic br, input logic ir, input logic st,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.iv = iv; v.ia = ia; v.ra = ra; v.rb = rb;
        v.ar = ar; v.br = br; v.ir = ir; v.st = st;
        v.we = we; v.wa = wa; v.wd = wd; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        A_Valid = 0; A_Addr = 0; A_Data = 0;
        B_Valid = 0; B_Addr = 0; B_Data = 0;
        Issue_Valid = 0; Issue_Addr = 0;
        Rd_Addr_A = 0; Rd_Addr_B = 0;
    endtask

    initial begin
        // av aa ad      bv ba bd    iv ia ra rb   ar br ir st we wa wd busy
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0, 0,0,0,0));
        vt.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0,
                        1,0,1,0, 0,0,0,0));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,
                        0,0,1,0, 1,5,32'hDEADBEEF,0));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0, 0,0,0,0));
        // contended run: A,B,A,B
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        1,0,1,0, 0,0,0,0));
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        0,1,1,0, 1,3,32'h33,0));
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        1,0,1,0, 1,4,32'h44,0));
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        0,1,1,0, 1,3,32'h33,0));
        vt.push_back(mk(1,3,32'h33, 0,0,0, 0,0,0,0,
                        1,0,1,0, 1,4,32'h44,0));
        // one more contended grant leaves the pointer on B
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        1,0,1,0, 1,3,32'h33,0));
        vt.push_back(mk(1,6,32'h66, 0,0,0, 0,0,0,0,
                        1,0,1,0, 1,3,32'h33,0));
        vt.push_back(mk(0,0,0, 1,4,32'h44, 0,0,0,0,
                        0,1,1,0, 1,6,32'h66,0));
        // zero address on A, B to 7; pointer stays B
        vt.push_back(mk(1,0,32'h1, 1,7,32'h77, 0,0,0,0,
                        1,1,1,0, 1,4,32'h44,0));
        vt.push_back(mk(1,3,32'h33, 1,4,32'h44, 0,0,0,0,
                        0,1,1,0, 1,7,32'h77,0));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,
                        0,0,1,0, 1,4,32'h44,0));
        vt.push_back(mk(1,0,32'h5, 1,0,32'h6, 0,0,0,0,
                        1,1,1,0, 0,0,0,0));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0, 0,0,0,0));
        // scoreboard
        vt.push_back(mk(0,0,0, 0,0,0, 1,9,0,0, 0,0,1,0, 0,0,0,0));
        vt.push_back(mk(0,0,0, 0,0,0, 1,9,9,0,
                        0,0,0,1, 0,0,0,32'h200));
        vt.push_back(mk(1,9,32'h99, 0,0,0, 0,0,9,0,
                        1,0,1,1, 0,0,0,32'h200));
        vt.push_back(mk(0,0,0, 0,0,0, 0,9,9,0,
                        0,0,0,1, 1,9,32'h99,32'h200));
        vt.push_back(mk(0,0,0, 0,0,0, 0,9,0,9, 0,0,1,0, 0,0,0,0));
        // unissued write-back of 12, issue 12 during its WE cycle
        vt.push_back(mk(1,12,32'hC, 0,0,0, 0,0,0,0,
                        1,0,1,0, 0,0,0,0));
        vt.push_back(mk(0,0,0, 0,0,0, 1,12,0,0,
                        0,0,1,0, 1,12,32'hC,0));
        vt.push_back(mk(0,0,0, 0,0,0, 1,0,12,0,
                        0,0,1,1, 0,0,0,32'h1000));
        vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,12,
                        0,0,1,1, 0,0,0,32'h1000));

        idle_inputs();
        RST = 1'b1;
        #3;
        check("reset_we", {31'd0, WE}, 32'd0);
        check("reset_waddr", {27'd0, W_Addr}, 32'd0);
        check("reset_wdata", W_Data, 32'd0);
        check("reset_busy", Busy, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vt[i]) begin
            @(negedge CLK);
            A_Valid = vt[i].av; A_Addr = vt[i].aa; A_Data = vt[i].ad;
            B_Valid = vt[i].bv; B_Addr = vt[i].ba; B_Data = vt[i].bd;
            Issue_Valid = vt[i].iv; Issue_Addr = vt[i].ia;
            Rd_Addr_A = vt[i].ra; Rd_Addr_B = vt[i].rb;
            #2;
            check($sformatf("v%0d_a_ready", i), {31'd0, A_Ready},
                  {31'd0, vt[i].ar});
            check($sformatf("v%0d_b_ready", i), {31'd0, B_Ready},
                  {31'd0, vt[i].br});
            check($sformatf("v%0d_issue_ready", i), {31'd0, Issue_Ready},
                  {31'd0, vt[i].ir});
            check($sformatf("v%0d_stall", i), {31'd0, Stall},
                  {31'd0, vt[i].st});
            check($sformatf("v%0d_we", i), {31'd0, WE},
                  {31'd0, vt[i].we});
            check($sformatf("v%0d_busy", i), Busy, vt[i].busy);
            if (vt[i].we) begin
                check($sformatf("v%0d_waddr", i), {27'd0, W_Addr},
                      {27'd0, vt[i].wa});
                check($sformatf("v%0d_wdata", i), W_Data, vt[i].wd);
            end
        end

        // contended grant moves pointer to B, then RST lands mid-WE
        @(negedge CLK);
        idle_inputs();
        A_Valid = 1; A_Addr = 3; A_Data = 32'h3;
        B_Valid = 1; B_Addr = 4; B_Data = 32'h4;
        #2;
        check("pre_rst_a_ready", {31'd0, A_Ready}, 32'd1);
        @(negedge CLK);
        idle_inputs();
        #1;
        check("mid_we_high", {31'd0, WE}, 32'd1);
        check("mid_we_addr", {27'd0, W_Addr}, 32'd3);
        RST = 1'b1;
        #1;
        check("rst_we_drop", {31'd0, WE}, 32'd0);
        check("rst_waddr", {27'd0, W_Addr}, 32'd0);
        check("rst_wdata", W_Data, 32'd0);
        check("rst_busy", Busy, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        A_Valid = 1; A_Addr = 3; A_Data = 32'h3;
        B_Valid = 1; B_Addr = 4; B_Data = 32'h4;
        #2;
        check("post_rst_rr_a", {31'd0, A_Ready}, 32'd1);
        check("post_rst_rr_b", {31'd0, B_Ready}, 32'd0);
        check("post_rst_we", {31'd0, WE}, 32'd0);
        @(negedge CLK);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and hazard scoreboard for the 32×32 two-read/one-write MIPS register file. It shares the single write port between two write-back requesters, ALU (A) and load unit (B), using valid/ready handshakes and round-robin arbitration. It also tracks registers with pending writes so the decoder can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file's W_Addr/W_Data/WE port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (NREG = 2**ADDR_W)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- A_Valid  in  1  ALU write-back request
- A_Addr  in  ADDR_W  ALU destination register
- A_Data  in  DATA_W  ALU result
- A_Ready  out  1  ALU request accepted this cycle
- B_Valid, B_Addr, B_Data, B_Ready  same as the A_* ports, for the load unit
- Issue_Valid  in  1  decoder issues an instruction that writes Issue_Addr
- Issue_Addr  in  ADDR_W  destination of the issuing instruction
- Issue_Ready  out  1  issue permitted (no WAW hazard)
- Rd_Addr_A, Rd_Addr_B  in  ADDR_W  decoder source registers
- Stall  out  1  RAW hazard on either source
- W_Addr  out  ADDR_W  to register file
- W_Data  out  DATA_W  to register file
- WE  out  1  to register file
- Busy  out  NREG  pending-write mask (debug/verification)

## Operation
- Transfer on X: X_Valid & X_Ready in the same cycle. Requesters hold Addr/Data stable while Valid is high and not accepted.
- Zero-address requests (X_Addr == 0) are always accepted immediately (X_Ready = 1). They are discarded: no port cycle, no WE. Both requesters can complete in the same cycle if one or both addresses are 0.
- Nonzero requests compete for the port. Arbitration:
  - Only one valid: that one is granted.
  - Both valid: the one indicated by the RR pointer is granted.
  - The RR pointer toggles to the loser only after a contended grant.
  - The RR pointer resets to A.
- The granted request is registered into W_Addr/W_Data with WE = 1 for exactly one cycle.
- At most one grant per cycle, so the write port is never oversubscribed. The port is fully pipelined; back-to-back grants are allowed.
- A_Ready and B_Ready are combinational from the Valid/Addr inputs and the RR pointer. They never depend on Issue_* or Rd_*.
- Scoreboard:
  - Issue_Valid & Issue_Ready & Issue_Addr != 0 sets Busy[Issue_Addr].
  - A WE cycle for W_Addr clears Busy[W_Addr] at the closing edge of that cycle.
  - If a set and a clear hit the same index at the same edge, the set wins.
- Issue_Ready = (Issue_Addr == 0) | ~Busy[Issue_Addr]. A second writer to a register that is still busy is therefore refused.
- Stall = (Rd_Addr_A != 0 & Busy[Rd_Addr_A]) | (Rd_Addr_B != 0 & Busy[Rd_Addr_B]). Combinational.
- Busy[0] is always 0.
- Write-backs are not checked against Busy; requesters are trusted to write only issued registers.

## Timing
- Reset values: W_Addr = 0, W_Data = 0, WE = 0, Busy = 0, RR pointer = A. Ready, Stall and Issue_Ready follow their inputs combinationally.
- Accept at edge n: WE high during cycle n+1, and the register file captures the data at the end of cycle n+1.
- Busy clears at that same edge; Stall drops in cycle n+2. A read issued in cycle n+2 captures the new value, because register-file reads are registered.
- Latency from issue to clearable: an issue accepted at edge k can be written back at the earliest with an accept at edge k, giving WE in k+1. If the clear lands on the same edge as the set, the set wins; this case cannot happen for a legal sequence.
- Asserting RST mid-operation aborts any pending WE immediately (asynchronous), clears Busy and drops in-flight data.

## Structure
- Package regfile_pkg: DATA_W, ADDR_W, NREG, and the requester-select enum {REQ_A, REQ_B}. These are shared with the register file and the decoder.
- Sub-module regfile_scoreboard contains the Busy flops, set/clear logic, Issue_Ready and Stall.
- The top level contains the arbiter, the RR pointer and the output register.

## Test plan
- Reset then idle: WE = 0, Busy = 0, A_Ready = 0 with no Valid. Assert RST mid-WE: WE drops immediately.
- A alone, Addr = 5, Data = 0xDEADBEEF:
  - A_Ready = 1 that cycle.
  - Next cycle WE = 1, W_Addr = 5, W_Data = 0xDEADBEEF.
  - The cycle after, WE = 0.
- A and B both valid for 4 cycles, Addr 3 and 4: grants alternate A, B, A, B with one WE per cycle. Then A alone is granted at once regardless of the pointer.
- A Addr = 0 and B Addr = 7 in the same cycle: both Ready = 1, a single WE to 7, RR pointer unchanged.
- Scoreboard:
  - Issue 9: Busy[9] = 1.
  - Rd_Addr_A = 9 gives Stall = 1.
  - A second Issue 9 sees Issue_Ready = 0.
  - Write-back of 9 clears Busy[9] after its WE cycle, then Stall = 0 and Issue_Ready = 1.
- Issue 12 at the same edge as the WE to 12 clears an earlier entry: Busy[12] ends 1 (set wins). Issue 0: Busy unchanged.
